// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the shared single-port DMEM.
// Fixed CPU priority with a starvation-forced DMA slot.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [3:0]            cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,
  input  logic                  dma_req,
  input  logic [3:0]            dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [31:0]           dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [31:0]           dma_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [15:0]           force_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    CPU_PRI,
    DMA_FORCE
  } state_e;

  typedef enum logic [1:0] {
    R_NONE,
    R_CPU,
    R_DMA
  } resp_e;

  state_e          state_q, state_d;
  resp_e           resp_q, resp_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [SW-1:0]   starve_inc;
  logic [15:0]     fcnt_q, fcnt_d;
  logic            gnt_cpu, gnt_dma;
  logic            lose, hit;

  // Grants are held low in reset so the memory port stays quiet.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if (rst_n) begin
      if (state_q == DMA_FORCE && dma_req) gnt_dma = 1'b1;
      else if (cpu_req)                    gnt_cpu = 1'b1;
      else if (dma_req)                    gnt_dma = 1'b1;
    end
  end

  assign lose       = dma_req & ~gnt_dma;
  assign starve_inc = starve_q + SW'(1);
  assign hit        = lose && (starve_inc == SW'(STARVE_LIMIT));

  always_comb begin
    starve_d = '0;
    state_d  = CPU_PRI;
    if (hit)       state_d  = DMA_FORCE;
    else if (lose) starve_d = starve_inc;
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (state_q == DMA_FORCE && gnt_dma && fcnt_q != 16'hFFFF)
      fcnt_d = fcnt_q + 16'd1;
  end

  always_comb begin
    resp_d = R_NONE;
    if (gnt_cpu && cpu_we == 4'd0)      resp_d = R_CPU;
    else if (gnt_dma && dma_we == 4'd0) resp_d = R_DMA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CPU_PRI;
      resp_q   <= R_NONE;
      starve_q <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      resp_q   <= resp_d;
      starve_q <= starve_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      gnt_cpu: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      gnt_dma: begin
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign mem_en     = gnt_cpu | gnt_dma;
  assign cpu_stall  = rst_n & cpu_req & ~gnt_cpu;
  assign dma_gnt    = dma_req & gnt_dma;
  assign cpu_rvalid = (resp_q == R_CPU);
  assign dma_rvalid = (resp_q == R_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : 32'd0;
  assign force_cnt  = fcnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, dma_req;
  logic [3:0]  cpu_we, dma_we, mem_we;
  logic [13:0] cpu_addr, dma_addr, mem_addr;
  logic [31:0] cpu_wdata, dma_wdata, mem_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_rdata;
  logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_en;
  logic [15:0] force_cnt;

  int n_chk = 0;
  int n_bad = 0;

  dmem_arbiter #(.ADDR_WIDTH(14), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .force_cnt(force_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  bit p_cpu, p_dma, e_dma;

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b1; dma_req = 1'b1;
    cpu_we = 4'd0; dma_we = 4'd0;
    cpu_addr = 14'h005; dma_addr = 14'h006;
    cpu_wdata = 32'd0; dma_wdata = 32'd0;
    mem_rdata = 32'h1234_5678;

    #2;
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_dgnt", 32'(dma_gnt), 32'd0);
    chk("rst_fcnt", 32'(force_cnt), 32'd0);
    cyc(); cyc();
    chk("rst_en2", 32'(mem_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_rv", 32'(cpu_rvalid), 32'd0);
    chk("rst_rd", cpu_rdata, 32'd0);

    rst_n = 1'b1;
    #1;
    chk("rel_en", 32'(mem_en), 32'd1);
    chk("rel_stall", 32'(cpu_stall), 32'd0);
    chk("rel_dgnt", 32'(dma_gnt), 32'd0);
    chk("rel_addr", 32'(mem_addr), 32'h005);

    cyc();
    cpu_req = 1'b0; dma_req = 1'b0;
    cyc();

    // CPU read
    cpu_req = 1'b1; cpu_addr = 14'h010;
    #1;
    chk("crd_en", 32'(mem_en), 32'd1);
    chk("crd_addr", 32'(mem_addr), 32'h010);
    chk("crd_we", 32'(mem_we), 32'd0);
    cyc();
    cpu_req = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("crd_rv", 32'(cpu_rvalid), 32'd1);
    chk("crd_rd", cpu_rdata, 32'hDEAD_BEEF);
    chk("crd_drv", 32'(dma_rvalid), 32'd0);
    chk("crd_drd", dma_rdata, 32'd0);

    // DMA write alone
    dma_req = 1'b1; dma_we = 4'b0011;
    dma_addr = 14'h020; dma_wdata = 32'h0000_ABCD;
    #1;
    chk("dwr_gnt", 32'(dma_gnt), 32'd1);
    chk("dwr_we", 32'(mem_we), 32'h3);
    chk("dwr_addr", 32'(mem_addr), 32'h020);
    chk("dwr_wd", mem_wdata, 32'h0000_ABCD);
    cyc();
    dma_req = 1'b0; dma_we = 4'd0;
    #1;
    chk("dwr_crv", 32'(cpu_rvalid), 32'd0);
    chk("dwr_drv", 32'(dma_rvalid), 32'd0);
    chk("dwr_drd", dma_rdata, 32'd0);

    // Continuous contention: forced DMA slot every 9th cycle
    cpu_addr = 14'h100; dma_addr = 14'h200;
    p_cpu = 1'b0; p_dma = 1'b0;
    for (int i = 0; i < 18; i++) begin
      cyc();
      cpu_req = 1'b1; dma_req = 1'b1;
      mem_rdata = 32'(i) + 32'h100;
      #1;
      e_dma = (i % 9 == 8);
      chk($sformatf("stv_dg%0d", i), 32'(dma_gnt), 32'(e_dma));
      chk($sformatf("stv_cs%0d", i), 32'(cpu_stall), 32'(e_dma));
      chk($sformatf("stv_ad%0d", i), 32'(mem_addr),
          e_dma ? 32'h200 : 32'h100);
      chk($sformatf("stv_cv%0d", i), 32'(cpu_rvalid), 32'(p_cpu));
      chk($sformatf("stv_dv%0d", i), 32'(dma_rvalid), 32'(p_dma));
      if (p_dma)
        chk($sformatf("stv_dd%0d", i), dma_rdata, 32'(i) + 32'h100);
      p_cpu = !e_dma;
      p_dma = e_dma;
    end
    cyc();
    cpu_req = 1'b0; dma_req = 1'b0;
    mem_rdata = 32'hCAFE_0001;
    #1;
    chk("stv_fcnt", 32'(force_cnt), 32'd2);
    chk("stv_lastdv", 32'(dma_rvalid), 32'd1);
    chk("stv_lastdd", dma_rdata, 32'hCAFE_0001);

    // Interrupted starvation: 5 losses, gap, then 8 more losses
    for (int j = 0; j < 15; j++) begin
      cyc();
      cpu_req = 1'b1;
      dma_req = (j != 5);
      #1;
      chk($sformatf("int_dg%0d", j), 32'(dma_gnt),
          32'(j == 14));
    end
    cyc();
    cpu_req = 1'b0; dma_req = 1'b0;
    #1;
    chk("int_fcnt", 32'(force_cnt), 32'd3);

    // DMA drops its request in the forced cycle
    for (int k = 0; k < 10; k++) begin
      cyc();
      cpu_req = 1'b1;
      dma_req = (k != 8);
      #1;
      chk($sformatf("drp_dg%0d", k), 32'(dma_gnt), 32'd0);
      chk($sformatf("drp_cs%0d", k), 32'(cpu_stall), 32'd0);
    end
    cyc();
    cpu_req = 1'b0; dma_req = 1'b0;
    #1;
    chk("drp_fcnt", 32'(force_cnt), 32'd3);

    // Reset lands between a CPU read grant and its response
    cyc();
    cpu_req = 1'b1; cpu_we = 4'd0; cpu_addr = 14'h033;
    #1;
    chk("mrs_en", 32'(mem_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrs_stall", 32'(cpu_stall), 32'd0);
    cyc();
    chk("mrs_rv", 32'(cpu_rvalid), 32'd0);
    chk("mrs_en0", 32'(mem_en), 32'd0);
    cpu_req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("mrs_rv2", 32'(cpu_rvalid), 32'd0);
    chk("mrs_fcnt", 32'(force_cnt), 32'd0);
    cyc();
    chk("mrs_rv3", 32'(cpu_rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port synchronous data memory between the CPU memory stage and a DMA engine. The CPU has fixed priority. A starvation counter forces one DMA grant after `STARVE_LIMIT` consecutive DMA losses, and the CPU is stalled for that cycle. The block sits between the pipeline's MEM stage / DMA engine and the DMEM block RAM, and routes 1-cycle-latency read data back to its owner.

## Interface
- `ADDR_WIDTH`, 14, word-address width of DMEM.
- `STARVE_LIMIT`, 8, consecutive DMA losses before a forced DMA grant; legal range 1..255.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `cpu_req`  input  1  CPU access request, valid this cycle.
- `cpu_we`  input  4  CPU byte write enables; 0 means read.
- `cpu_addr`  input  ADDR_WIDTH  CPU word address.
- `cpu_wdata`  input  32  CPU write data.
- `cpu_stall`  output  1  CPU request not granted this cycle.
- `cpu_rvalid`  output  1  CPU read data valid.
- `cpu_rdata`  output  32  CPU read data.
- `dma_req`, `dma_we[3:0]`, `dma_addr[ADDR_WIDTH-1:0]`, `dma_wdata[31:0]`  input  DMA request fields, same meaning as the CPU fields.
- `dma_gnt`  output  1  DMA request granted this cycle.
- `dma_rvalid`  output  1  DMA read data valid.
- `dma_rdata`  output  32  DMA read data.
- `mem_en`, `mem_we[3:0]`, `mem_addr[ADDR_WIDTH-1:0]`, `mem_wdata[31:0]`  output  DMEM port driven from the granted requester.
- `mem_rdata`  input  32  DMEM read data, valid 1 cycle after a read is issued.
- `force_cnt`  output  16  count of forced DMA grants; saturates at 0xFFFF.

## Operation
- States:
  - `CPU_PRI` (reset state).
  - `DMA_FORCE`.
- Grant in `CPU_PRI`:
  - If `cpu_req`, grant the CPU.
  - Else if `dma_req`, grant the DMA.
- Grant in `DMA_FORCE`:
  - If `dma_req`, grant the DMA.
  - Otherwise use the `CPU_PRI` rule.
  - The next state is always `CPU_PRI`.
- Starvation counter `starve`, width `$clog2(STARVE_LIMIT+1)`:
  - Increments when `dma_req` is high and the DMA is not granted.
  - Clears when the DMA is granted or `dma_req` is low.
  - When an increment would reach `STARVE_LIMIT`, the counter clears and the next state is `DMA_FORCE`.
- `force_cnt` increments on every `DMA_FORCE` cycle in which the DMA is granted; it saturates at 0xFFFF.
- Outputs:
  - `cpu_stall = cpu_req & ~cpu_granted`.
  - `dma_gnt = dma_req & dma_granted`.
  - `mem_en` = any grant.
  - `mem_we`, `mem_addr` and `mem_wdata` mux from the granted requester; all zero when there is no grant.
- Response routing:
  - A registered `resp_sel` ∈ {NONE, CPU, DMA} loads the owner of a granted read (`we == 0`).
  - Writes and idle cycles load NONE.
  - `cpu_rvalid = (resp_sel == CPU)` and `dma_rvalid = (resp_sel == DMA)`.
  - `cpu_rdata` / `dma_rdata` equal `mem_rdata` when the matching rvalid is high, else 0.
- A stalled requester holds its request fields stable until granted. The arbiter does not queue requests.

## Timing
- Grant, `cpu_stall`, `dma_gnt` and the `mem_*` outputs are combinational from the current request and state: 0-cycle arbitration.
- Read latency is exactly 1 cycle: grant in cycle N gives rvalid and rdata in cycle N+1.
- Back-to-back reads from either requester give one response per cycle.
- Simultaneous requests:
  - The CPU wins in `CPU_PRI`.
  - The DMA wins in `DMA_FORCE`, with `cpu_stall` = 1.
- With both requesters continuously requesting, the DMA is granted once every `STARVE_LIMIT+1` cycles.
- If `dma_req` drops in `DMA_FORCE`:
  - The CPU is granted that cycle.
  - `force_cnt` does not increment.
  - The state returns to `CPU_PRI`.
- While `rst_n` = 0:
  - State is `CPU_PRI`, `starve` = 0, `resp_sel` = NONE, `force_cnt` = 0.
  - Outputs are forced: `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_stall` = 0, `dma_gnt` = 0, both rvalid = 0, both rdata = 0.
- Reset asserted mid-read: the pending response is discarded; rvalid is not asserted after release.
- First grant is possible in the first cycle with `rst_n` = 1.

## Test plan
- Reset: hold `rst_n`=0 with `cpu_req`=`dma_req`=1 → `mem_en`=0, `cpu_stall`=0, `dma_gnt`=0, `force_cnt`=0. After release → CPU granted the same cycle.
- CPU read: `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x010, memory returns 0xDEADBEEF → `mem_addr`=0x010 in cycle N; `cpu_rvalid`=1 and `cpu_rdata`=0xDEADBEEF in N+1; `dma_rvalid`=0.
- DMA write alone: `dma_req`=1, `dma_we`=4'b0011, `dma_addr`=0x020, `dma_wdata`=0x0000ABCD → `dma_gnt`=1 and `mem_we`=0011 the same cycle; no rvalid in N+1.
- Starvation, `STARVE_LIMIT`=8, both requesting reads continuously:
  - CPU granted in cycles 0–7.
  - Cycle 8: `dma_gnt`=1, `cpu_stall`=1, `dma_rvalid`=1 in cycle 9.
  - Pattern repeats with period 9; `force_cnt`=2 after 18 cycles.
- Interrupted starvation: `dma_req` high for 5 losing cycles, low for 1, high again → no forced grant until 8 further losses.
- Reset mid-read: CPU read granted in cycle N, `rst_n`=0 in N+1 → `cpu_rvalid`=0 throughout; `force_cnt`=0 after release.
